// File: rtl/aes_pkg.sv
// Shared AES constants and the key-schedule state type.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SUB,
    COMBINE,
    DONE,
    HOLD
  } keyexp_state_t;

  localparam logic [3:0] ROUND_FIRST = 4'd1;
  localparam logic [3:0] ROUND_LAST  = 4'd11;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational table lookup.
module aes_sbox (
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  always_comb sbox_out = SBOX[sbox_in];

endmodule

// File: rtl/aes_key_expansion.sv
// On-the-fly AES-128 key schedule: one round key per request, one S-box byte per cycle.
module aes_key_expansion
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         readk_enable,
  input  logic [127:0] key_in,
  input  logic         keyexp_enable,
  input  logic [3:0]   roundnum,
  output logic [127:0] round_key,
  output logic         keyexp_finished
);

  keyexp_state_t state_q, state_d;

  logic [127:0] cipher_key;
  logic [31:0]  temp, temp_sub, t;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic [1:0]   byte_idx;
  logic [7:0]   sbox_in, sbox_out, rcon_sel;
  logic         round_ok;

  aes_sbox u_sbox (
    .sbox_in  (sbox_in),
    .sbox_out (sbox_out)
  );

  always_comb round_ok = (roundnum > ROUND_FIRST) && (roundnum <= ROUND_LAST);

  // Bytes of temp are substituted MSB-first.
  always_comb begin
    sbox_in = temp[31:24];
    case (byte_idx)
      2'd0: sbox_in = temp[31:24];
      2'd1: sbox_in = temp[23:16];
      2'd2: sbox_in = temp[15:8];
      2'd3: sbox_in = temp[7:0];
      default: sbox_in = temp[31:24];
    endcase
  end

  always_comb begin
    temp_sub = temp;
    case (byte_idx)
      2'd0: temp_sub[31:24] = sbox_out;
      2'd1: temp_sub[23:16] = sbox_out;
      2'd2: temp_sub[15:8]  = sbox_out;
      2'd3: temp_sub[7:0]   = sbox_out;
      default: temp_sub = temp;
    endcase
  end

  always_comb begin
    rcon_sel = '0;
    for (int unsigned i = 1; i <= 10; i++) begin
      if (roundnum == 4'(i + 1)) rcon_sel = RCON[i];
    end
  end

  always_comb begin
    t   = temp ^ {rcon_sel, 24'h0};
    w0n = round_key[127:96] ^ t;
    w1n = round_key[95:64]  ^ w0n;
    w2n = round_key[63:32]  ^ w1n;
    w3n = round_key[31:0]   ^ w2n;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (keyexp_enable) state_d = round_ok ? SUB : DONE;
      end
      SUB:     if (byte_idx == 2'd3) state_d = COMBINE;
      COMBINE: state_d = DONE;
      DONE:    state_d = HOLD;
      HOLD:    if (!keyexp_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (readk_enable) state_d = IDLE;
  end

  always_comb keyexp_finished = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cipher_key <= '0;
      round_key  <= '0;
      temp       <= '0;
      byte_idx   <= '0;
    end else if (readk_enable) begin
      cipher_key <= key_in;
      round_key  <= key_in;
    end else begin
      case (state_q)
        IDLE: begin
          if (keyexp_enable) begin
            if (roundnum == ROUND_FIRST) begin
              round_key <= cipher_key;
            end else if (round_ok) begin
              temp     <= {round_key[23:0], round_key[31:24]};
              byte_idx <= '0;
            end
          end
        end
        SUB: begin
          temp     <= temp_sub;
          byte_idx <= byte_idx + 2'd1;
        end
        COMBINE: round_key <= {w0n, w1n, w2n, w3n};
        default: ;
      endcase
    end
  end

endmodule
